// File: rtl/perceptron_seq.sv
// rtl/perceptron_seq.sv - element assembly, weight/bias store and result capture around the perceptron; optional PERCEPTRON_SEQ_PERF_EN counters
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module perceptron_seq #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int LATENCY    = 1,
    parameter int AW         = $clog2(N + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             wr_en,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [N-1:0][DATA_WIDTH-1:0]     x_vec,
    output logic [N-1:0][DATA_WIDTH-1:0]     w_vec,
    output logic [DATA_WIDTH-1:0]            bias,
    input  logic [DATA_WIDTH-1:0]            y_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
`ifdef PERCEPTRON_SEQ_PERF_EN
    output logic [15:0]                      vec_count,
    output logic [7:0]                       drop_count,
`endif
    output logic                             busy
);

    localparam int CW = $clog2(N);
    localparam int WW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_OUT} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 elem_cnt_q, elem_cnt_d;
    logic [WW-1:0]                 wait_cnt_q, wait_cnt_d;
    logic [N-1:0][DATA_WIDTH-1:0]  x_q, x_d;
    logic [N-1:0][DATA_WIDTH-1:0]  w_q, w_d;
    logic [DATA_WIDTH-1:0]         bias_q, bias_d;
    logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
`ifdef PERCEPTRON_SEQ_PERF_EN
    logic [15:0]                   vec_count_q, vec_count_d;
    logic [7:0]                    drop_count_q, drop_count_d;
`endif

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        wait_cnt_d = wait_cnt_q;
        x_d        = x_q;
        w_d        = w_q;
        bias_d     = bias_q;
        out_data_d = out_data_q;
`ifdef PERCEPTRON_SEQ_PERF_EN
        vec_count_d  = vec_count_q;
        drop_count_d = drop_count_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (elem_cnt_q == CW'(i)) x_d[i] = in_data;
                    end
                    if (elem_cnt_q == CW'(N - 1)) begin
                        elem_cnt_d = '0;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        elem_cnt_d = elem_cnt_q + CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                // y_in is sampled once the perceptron register has seen stable inputs
                if (wait_cnt_q == WW'(LATENCY)) begin
                    out_data_d = y_in;
                    wait_cnt_d = '0;
                    state_d    = ST_OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_LOAD;
`ifdef PERCEPTRON_SEQ_PERF_EN
                    vec_count_d = vec_count_q + 16'd1;
`endif
                end
            end
            default: state_d = ST_LOAD;
        endcase

        // Writes during WAIT are dropped so the datapath inputs stay frozen
        if (wr_en && state_q != ST_WAIT) begin
            for (int i = 0; i < N; i++) begin
                if (wr_addr == AW'(i)) w_d[i] = wr_data;
            end
            if (wr_addr == AW'(N)) bias_d = wr_data;
        end
`ifdef PERCEPTRON_SEQ_PERF_EN
        if (wr_en && state_q == ST_WAIT && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            elem_cnt_q <= '0;
            wait_cnt_q <= '0;
            x_q        <= '0;
            w_q        <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
`ifdef PERCEPTRON_SEQ_PERF_EN
            vec_count_q  <= '0;
            drop_count_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            x_q        <= x_d;
            w_q        <= w_d;
            bias_q     <= bias_d;
            out_data_q <= out_data_d;
`ifdef PERCEPTRON_SEQ_PERF_EN
            vec_count_q  <= vec_count_d;
            drop_count_q <= drop_count_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign out_valid = (state_q == ST_OUT);
    assign x_vec     = x_q;
    assign w_vec     = w_q;
    assign bias      = bias_q;
    assign out_data  = out_data_q;
`ifdef PERCEPTRON_SEQ_PERF_EN
    assign vec_count  = vec_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_perceptron_seq.sv
// tb/tb_perceptron_seq.sv - randomized directed bench for perceptron_seq against an array-based reference model
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_perceptron_seq;

    localparam int N       = 4;
    localparam int DW      = `DATA_WIDTH;
    localparam int LATENCY = 1;
    localparam int AW      = $clog2(N + 1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [DW-1:0]            in_data = '0;
    logic                     wr_en = 1'b0;
    logic [AW-1:0]            wr_addr = '0;
    logic [DW-1:0]            wr_data = '0;
    logic [N-1:0][DW-1:0]     x_vec;
    logic [N-1:0][DW-1:0]     w_vec;
    logic [DW-1:0]            bias;
    logic [DW-1:0]            y_in = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [DW-1:0]            out_data;
    logic                     busy;
`ifdef PERCEPTRON_SEQ_PERF_EN
    logic [15:0]              vec_count;
    logic [7:0]               drop_count;
`endif

    perceptron_seq #(.N(N), .DATA_WIDTH(DW), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .x_vec(x_vec), .w_vec(w_vec), .bias(bias), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef PERCEPTRON_SEQ_PERF_EN
        .vec_count(vec_count), .drop_count(drop_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] x_m [N];
    logic [DW-1:0] w_m [N];
    logic [DW-1:0] b_m;
    int            vec_m  = 0;
    int            drop_m = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] a [N]);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            x_m[i] = '0;
            w_m[i] = '0;
        end
        b_m = '0;
        vec_m = 0;
        drop_m = 0;
    endtask

    // Model rule: writes land only outside WAIT; addr N is bias, above N is ignored
    task automatic model_write(input int addr, input logic [DW-1:0] d, input bit in_wait);
        if (in_wait) drop_m = (drop_m == 255) ? 255 : drop_m + 1;
        else if (addr < N) w_m[addr] = d;
        else if (addr == N) b_m = d;
    endtask

    task automatic write(input int addr, input logic [DW-1:0] d, input bit in_wait);
        wr_en = 1'b1;
        wr_addr = AW'(addr);
        wr_data = d;
        step();
        wr_en = 1'b0;
        model_write(addr, d, in_wait);
    endtask

    task automatic accept_elem(input logic [DW-1:0] d, input int gaps);
        bit got = 0;
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data = DW'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 20; k++) begin
            got = in_ready;
            step();
            if (got) break;
        end
        in_valid = 1'b0;
        in_data = DW'($urandom);
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // Streams x_m; a write may be issued alongside the final element
    task automatic send_vec(input int maxgap, input bit last_wr, input int waddr, input logic [DW-1:0] wdata);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1 && last_wr) begin
                wr_en = 1'b1;
                wr_addr = AW'(waddr);
                wr_data = wdata;
            end
            accept_elem(x_m[i], (maxgap == 0) ? 0 : $urandom_range(maxgap, 0));
            if (i == N - 1 && last_wr) begin
                wr_en = 1'b0;
                model_write(waddr, wdata, 1'b0);
            end
        end
        chk("in_ready_after_last", 64'(in_ready), 64'd0);
        chk("busy_in_wait", 64'(busy), 64'd1);
        chk("x_vec_in_wait", 64'(x_vec), 64'(pack(x_m)));
    endtask

    // startc = cycles already elapsed since the last-accept edge
    task automatic wait_result(input logic [DW-1:0] yv, input int startc);
        int c = startc;
        while (!out_valid && c < 10) begin
            y_in = (c >= 1) ? yv : DW'($urandom);
            step();
            c++;
        end
        chk("result_latency", 64'(c), 64'(LATENCY + 1));
        chk("out_data", 64'(out_data), 64'(yv));
        chk("x_vec_frozen", 64'(x_vec), 64'(pack(x_m)));
        y_in = DW'($urandom);
    endtask

    task automatic take_result(input int delay, input logic [DW-1:0] yv);
        out_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(yv));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vec_m = (vec_m + 1) & 16'hFFFF;
        chk("valid_after_hs", 64'(out_valid), 64'd0);
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_w_vec"}, 64'(w_vec), 64'(pack(w_m)));
        chk({tag, "_bias"}, 64'(bias), 64'(b_m));
`ifdef PERCEPTRON_SEQ_PERF_EN
        chk({tag, "_vec_count"}, 64'(vec_count), 64'(vec_m));
        chk({tag, "_drop_count"}, 64'(drop_count), 64'(drop_m));
`endif
    endtask

    initial begin
        logic [DW-1:0] yv;
        model_clear();
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x_vec", 64'(x_vec), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        check_regs("rst");

        // Directed vector, continuous valid
        for (int i = 0; i < N; i++) write(i, DW'(i + 1), 1'b0);
        write(N, DW'(5), 1'b0);
        check_regs("load_w");
        x_m[0] = DW'(10); x_m[1] = DW'(-3); x_m[2] = DW'(7); x_m[3] = DW'(0);
        send_vec(0, 1'b0, 0, '0);
        wait_result(DW'(42), 0);
        take_result(10, DW'(42));

        // Gapped input, dropped write in WAIT, accepted write in OUT, out-of-range write
        for (int i = 0; i < N; i++) x_m[i] = DW'($urandom);
        for (int i = 0; i < N; i++) accept_elem(x_m[i], 1);
        chk("gap_in_ready", 64'(in_ready), 64'd0);
        chk("gap_x_vec", 64'(x_vec), 64'(pack(x_m)));
        write(0, DW'(99), 1'b1);
        check_regs("wait_write");
        yv = DW'($urandom);
        wait_result(yv, 1);
        write(0, DW'(99), 1'b0);
        check_regs("out_write");
        write(N + 1, DW'(77), 1'b0);
        check_regs("bad_addr");
        take_result($urandom_range(3, 0), yv);

        // Random vectors, weights and backpressure; iteration 1 writes on the last accept
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i <= N; i++) write(i, DW'($urandom), 1'b0);
            for (int i = 0; i < N; i++) x_m[i] = DW'($urandom);
            send_vec(2, it == 1, $urandom_range(N, 0), DW'($urandom));
            check_regs("rand_wait");
            yv = DW'($urandom);
            wait_result(yv, 0);
            take_result($urandom_range(3, 0), yv);
        end

        // Reset mid-vector
        accept_elem(DW'($urandom), 0);
        accept_elem(DW'($urandom), 0);
        #2 rst_n = 1'b0;
        #2;
        model_clear();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_x_vec", 64'(x_vec), 64'd0);
        check_regs("midrst");
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < N; i++) x_m[i] = DW'($urandom);
        for (int i = 0; i < N - 1; i++) begin
            accept_elem(x_m[i], 0);
            chk("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        accept_elem(x_m[N-1], 0);
        chk("post_rst_x_vec", 64'(x_vec), 64'(pack(x_m)));
        yv = DW'($urandom);
        wait_result(yv, 0);
        take_result(1, yv);
        check_regs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perceptron_seq.md
Name: perceptron_seq

Overview:
- Sequencing front/back end for the single-neuron datapath. It sits directly upstream of the perceptron (dot product, bias, quantizer, ReLU, one output register) and consumes that perceptron's output.
- Accepts input-vector elements one per handshake on a valid/ready stream. Assembles N elements into a held vector.
- Holds the locally stored weights and bias stable for the perceptron. Waits out the perceptron's register latency, captures the activated value y and presents it on a valid/ready result stream.

Parameters:
- N, 4, vector dimensionality; must be >= 2.
- DATA_WIDTH, `DATA_WIDTH, element/weight/bias/result width (signed).
- LATENCY, 1, perceptron clock cycles from stable inputs to registered y; must be >= 1.
- AW, $clog2(N+1), weight-write address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input element valid.
- in_ready  out  1  element accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  signed input element.
- wr_en  in  1  weight/bias write strobe.
- wr_addr  in  AW  0..N-1 selects w[i]; N selects bias; >N ignored.
- wr_data  in  DATA_WIDTH  signed weight/bias value.
- x_vec  out  DATA_WIDTH x N  assembled vector to perceptron x.
- w_vec  out  DATA_WIDTH x N  weight registers to perceptron w.
- bias  out  DATA_WIDTH  bias register to perceptron b.
- y_in  in  DATA_WIDTH  perceptron y.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  DATA_WIDTH  captured y.
- busy  out  1  high in WAIT and OUT.

Behaviour:
- Reset (async, rst_n low) clears all state:
  - State goes to LOAD; elem_cnt=0; wait_cnt=0.
  - x_vec, w_vec, bias and out_data are all 0.
  - out_valid=0, busy=0, in_ready=1 while not in reset.
  - Reset mid-operation discards any partial vector and any pending result, with no output.
- States: LOAD, WAIT, OUT. in_ready = (state==LOAD). busy = (state!=LOAD). out_valid = (state==OUT), registered.
- LOAD:
  - On each element handshake: x_vec[elem_cnt] <= in_data; elem_cnt increments.
  - Handshake with elem_cnt==N-1: elem_cnt <= 0, wait_cnt <= 0, state -> WAIT.
  - No handshake: hold everything; x_vec partial contents are don't-care downstream.
- WAIT:
  - x_vec, w_vec and bias are frozen; wait_cnt increments each cycle.
  - At the edge where wait_cnt==LATENCY: out_data <= y_in; state -> OUT.
  - WAIT therefore lasts LATENCY+1 cycles. out_valid rises LATENCY+1 cycles after the edge accepting the last element (2 cycles at default).
- OUT:
  - out_data is held stable while out_valid is high.
  - Handshake: state -> LOAD; in_ready is high the next cycle. There is no overlap: the first element of the next vector cannot be accepted in the handshake cycle.
  - out_ready low: stay in OUT indefinitely.
- Weight/bias writes:
  - Accepted in LOAD and OUT. Ignored (dropped, no effect) in WAIT so the datapath inputs stay stable.
  - wr_addr>N is ignored.
  - A write in the same cycle as the last-element handshake is accepted; it is visible from WAIT's first cycle.
- Counters:
  - elem_cnt is $clog2(N) bits wide, never exceeds N-1, and wraps only via the explicit clear.
  - wait_cnt is sized to hold LATENCY.
- No arithmetic in this block; values pass through unmodified (signed, DATA_WIDTH).

Optional Feature:
- Macro: PERCEPTRON_SEQ_PERF_EN.
- Defined:
  - Adds output port vec_count, 16 bits, reset 0.
  - Increments on each out handshake; wraps 0xFFFF->0x0000.
  - Adds output drop_count, 8 bits, reset 0. It increments on each write ignored in WAIT and saturates at 0xFF.
- Undefined: neither port nor its counters exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle: check in_ready=1, out_valid=0, busy=0, x_vec/w_vec/bias/out_data all 0.
- Load w={1,2,3,4} and bias=5, then stream x={10,-3,7,0} with in_valid always high:
  - in_ready drops after the 4th element.
  - x_vec holds {10,-3,7,0} through WAIT.
  - Bench drives y_in=42 one cycle into WAIT; out_data=42 and out_valid rise exactly 2 cycles after the last accept.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_data=42 stay stable, in_ready stays 0. Raise out_ready -> one handshake, in_ready=1 the next cycle.
- Gapped input: toggle in_valid every other cycle for 4 elements -> only handshake cycles store data; WAIT is entered after the 4th accept.
- Write wr_addr=0, wr_data=99 during WAIT -> w_vec[0] unchanged. The same write in OUT -> w_vec[0]=99. wr_addr=N+1 -> no change anywhere.
- Assert rst_n=0 after 2 of 4 elements, release, stream 4 new elements -> result taken from the new vector only, with no spurious out_valid. With PERCEPTRON_SEQ_PERF_EN: vec_count counts completed results; drop_count=1 after the WAIT write.
